// File: rtl/ram_fifo_controller.sv
// First-word-fall-through FIFO controller driving a true_dual_port_ram (port 0 write, port 1 read).
// Optional sticky overflow/underflow flags are enabled by defining RAM_FIFO_ERROR_FLAGS_EN.
module ram_fifo_controller #(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 16,
  parameter int ADDRESS_WIDTH          = $clog2(DEPTH),
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ram_port_0_write_enable,
  output logic                     ram_port_0_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_port_0_address,
  output logic [WIDTH-1:0]         ram_port_0_write_data,
  output logic                     ram_port_1_write_enable,
  output logic                     ram_port_1_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_port_1_address,
  output logic [WIDTH-1:0]         ram_port_1_write_data,
  input  logic [WIDTH-1:0]         ram_port_1_read_data
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   FULL_LEVEL   = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   AF_LEVEL     = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [ADDRESS_WIDTH:0]   AE_LEVEL     = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);

  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [ADDRESS_WIDTH-1:0] read_pointer;
  logic                     push;
  logic                     pop;

  always_comb begin
    empty        = (level == '0);
    full         = (level == FULL_LEVEL);
    almost_full  = (level >= AF_LEVEL);
    almost_empty = (level <= AE_LEVEL);
    push         = write_enable & ~full;
    pop          = read_enable & ~empty;
  end

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      level         <= '0;
    end else begin
      if (push) write_pointer <= (write_pointer == LAST_ADDRESS) ? '0 : write_pointer + 1'b1;
      if (pop)  read_pointer  <= (read_pointer == LAST_ADDRESS) ? '0 : read_pointer + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef RAM_FIFO_ERROR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write_enable && full) overflow_q  <= 1'b1;
      if (read_enable && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign read_data               = empty ? '0 : ram_port_1_read_data;
  assign ram_port_0_write_enable = push;
  assign ram_port_0_read_enable  = 1'b0;
  assign ram_port_0_address      = write_pointer;
  assign ram_port_0_write_data   = write_data;
  assign ram_port_1_write_enable = 1'b0;
  assign ram_port_1_read_enable  = ~empty;
  assign ram_port_1_address      = read_pointer;
  assign ram_port_1_write_data   = '0;

endmodule

// File: tb/tb_ram_fifo_controller.sv
// Bench for ram_fifo_controller: DEPTH=4 and DEPTH=5 instances share stimulus, each with a RAM model
// and a queue-based reference. Define RAM_FIFO_ERROR_FLAGS_EN to check the sticky error flags.
module tb_ram_fifo_controller;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       write_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic [7:0] write_data = 8'h00;

  logic [2:0] l4;
  logic e4, f4, af4, ae4, ov4, un4, p0we4, p0re4, p1we4, p1re4;
  logic [7:0] rd4, p0wd4, p1wd4, p1rd4;
  logic [1:0] p0a4, p1a4;

  logic [3:0] l5;
  logic e5, f5, af5, ae5, ov5, un5, p0we5, p0re5, p1we5, p1re5;
  logic [7:0] rd5, p0wd5, p1wd5, p1rd5;
  logic [2:0] p0a5, p1a5;

  ram_fifo_controller #(.WIDTH(8), .DEPTH(4)) u4 (
    .clock(clock), .resetn(resetn), .write_enable(write_enable), .write_data(write_data),
    .full(f4), .almost_full(af4), .read_enable(read_enable), .read_data(rd4), .empty(e4),
    .almost_empty(ae4), .level(l4), .overflow(ov4), .underflow(un4),
    .ram_port_0_write_enable(p0we4), .ram_port_0_read_enable(p0re4), .ram_port_0_address(p0a4),
    .ram_port_0_write_data(p0wd4), .ram_port_1_write_enable(p1we4), .ram_port_1_read_enable(p1re4),
    .ram_port_1_address(p1a4), .ram_port_1_write_data(p1wd4), .ram_port_1_read_data(p1rd4)
  );

  ram_fifo_controller #(.WIDTH(8), .DEPTH(5)) u5 (
    .clock(clock), .resetn(resetn), .write_enable(write_enable), .write_data(write_data),
    .full(f5), .almost_full(af5), .read_enable(read_enable), .read_data(rd5), .empty(e5),
    .almost_empty(ae5), .level(l5), .overflow(ov5), .underflow(un5),
    .ram_port_0_write_enable(p0we5), .ram_port_0_read_enable(p0re5), .ram_port_0_address(p0a5),
    .ram_port_0_write_data(p0wd5), .ram_port_1_write_enable(p1we5), .ram_port_1_read_enable(p1re5),
    .ram_port_1_address(p1a5), .ram_port_1_write_data(p1wd5), .ram_port_1_read_data(p1rd5)
  );

  // RAM models: synchronous write, combinational read
  logic [7:0] ram4 [4];
  logic [7:0] ram5 [8];
  always @(posedge clock) if (p0we4) ram4[p0a4] <= p0wd4;
  always @(posedge clock) if (p0we5) ram5[p0a5] <= p0wd5;
  assign p1rd4 = ram4[p1a4];
  assign p1rd5 = ram5[p1a5];

  int total = 0;
  int bad = 0;

  logic [7:0] m4[$];
  logic [7:0] m5[$];
  bit ov4m = 0, un4m = 0, ov5m = 0, un5m = 0;
  int wp4 = 0, rp4 = 0, wp5 = 0, rp5 = 0;

  function automatic logic [16:0] exp4();
    int n = m4.size();
    return {3'(n), n == 0, n == 4, n >= 3, n <= 1, ov4m, un4m, (n != 0) ? m4[0] : 8'h00};
  endfunction

  function automatic logic [17:0] exp5();
    int n = m5.size();
    return {4'(n), n == 0, n == 5, n >= 4, n <= 1, ov5m, un5m, (n != 0) ? m5[0] : 8'h00};
  endfunction

  task automatic clear_model();
    m4.delete(); m5.delete();
    ov4m = 0; un4m = 0; ov5m = 0; un5m = 0;
    wp4 = 0; rp4 = 0; wp5 = 0; rp5 = 0;
  endtask

  // Drive one cycle of stimulus and advance the reference model across the clock edge.
  task automatic step(input logic we, input logic re, input logic [7:0] wd);
    bit ps4, pp4, ps5, pp5;
    write_enable = we; read_enable = re; write_data = wd;
    ps4 = we && m4.size() < 4;  pp4 = re && m4.size() != 0;
    ps5 = we && m5.size() < 5;  pp5 = re && m5.size() != 0;
`ifdef RAM_FIFO_ERROR_FLAGS_EN
    if (we && m4.size() == 4) ov4m = 1;
    if (re && m4.size() == 0) un4m = 1;
    if (we && m5.size() == 5) ov5m = 1;
    if (re && m5.size() == 0) un5m = 1;
`endif
    @(posedge clock);
    if (pp4) begin void'(m4.pop_front()); rp4++; end
    if (ps4) begin m4.push_back(wd); wp4++; end
    if (pp5) begin void'(m5.pop_front()); rp5++; end
    if (ps5) begin m5.push_back(wd); wp5++; end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({l4, e4, f4, af4, ae4, ov4, un4, rd4} !== exp4()) begin
      bad++; $display("FAIL reset_state4 got=%h exp=%h", {l4, e4, f4, af4, ae4, ov4, un4, rd4}, exp4());
    end
    total++;
    if ({l5, e5, f5, af5, ae5, ov5, un5, rd5} !== exp5()) begin
      bad++; $display("FAIL reset_state5 got=%h exp=%h", {l5, e5, f5, af5, ae5, ov5, un5, rd5}, exp5());
    end
    total++;
    if ({p0we4, p0re4, p1we4, p1re4, p0we5, p0re5, p1we5, p1re5} !== 8'h00) begin
      bad++; $display("FAIL reset_ram_enables got=%b exp=00000000",
                      {p0we4, p0re4, p1we4, p1re4, p0we5, p0re5, p1we5, p1re5});
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i]);
      total++;
      if ({l4, e4, f4, af4, ae4, ov4, un4, rd4} !== exp4()) begin
        bad++; $display("FAIL fill_state4 i=%0d got=%h exp=%h", i, {l4, e4, f4, af4, ae4, ov4, un4, rd4}, exp4());
      end
      total++;
      if (af4 !== (i >= 2)) begin
        bad++; $display("FAIL fill_almost_full4 i=%0d got=%b exp=%b", i, af4, i >= 2);
      end
    end
    total++;
    if ({f4, l4, f5, l5} !== {1'b1, 3'd4, 1'b0, 4'd4}) begin
      bad++; $display("FAIL fill_full got=%h exp=%h", {f4, l4, f5, l5}, {1'b1, 3'd4, 1'b0, 4'd4});
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rd4, rd5} !== {vals[i], vals[i]}) begin
        bad++; $display("FAIL drain_order i=%0d got=%h exp=%h", i, {rd4, rd5}, {vals[i], vals[i]});
      end
      step(1'b0, 1'b1, 8'h00);
    end
    total++;
    if ({e4, e5, l4, l5, rd4, rd5} !== {2'b11, 3'd0, 4'd0, 16'h0000}) begin
      bad++; $display("FAIL drain_empty got=%h exp=%h", {e4, e5, l4, l5, rd4, rd5}, {2'b11, 3'd0, 4'd0, 16'h0000});
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 8'($urandom));
      total++;
      if ({l5, e5, f5, af5, ae5, ov5, un5, rd5} !== exp5()) begin
        bad++; $display("FAIL wrap_state5 i=%0d got=%h exp=%h", i, {l5, e5, f5, af5, ae5, ov5, un5, rd5}, exp5());
      end
      total++;
      if ({l4, e4, f4, af4, ae4, ov4, un4, rd4} !== exp4()) begin
        bad++; $display("FAIL wrap_state4 i=%0d got=%h exp=%h", i, {l4, e4, f4, af4, ae4, ov4, un4, rd4}, exp4());
      end
      total++;
      if ({p0a5, p1a5} !== {3'(wp5 % 5), 3'(rp5 % 5)}) begin
        bad++; $display("FAIL wrap_pointers5 i=%0d got=%h exp=%h", i, {p0a5, p1a5}, {3'(wp5 % 5), 3'(rp5 % 5)});
      end
    end
  endtask

  task automatic test_full_collision();
    int guard;
    step(1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b0, 8'h77);
    total++;
    if ({f4, l4} !== {1'b1, 3'd4}) begin
      bad++; $display("FAIL collide_prefull got=%h exp=%h", {f4, l4}, {1'b1, 3'd4});
    end
    step(1'b1, 1'b1, 8'h55);
    total++;
    if ({l4, l5} !== {3'd3, 4'd4}) begin
      bad++; $display("FAIL collide_full_level got=%h exp=%h", {l4, l5}, {3'd3, 4'd4});
    end
    total++;
    if ({l4, e4, f4, af4, ae4, ov4, un4, rd4} !== exp4()) begin
      bad++; $display("FAIL collide_full_state4 got=%h exp=%h", {l4, e4, f4, af4, ae4, ov4, un4, rd4}, exp4());
    end
    guard = 0;
    while ((m4.size() != 0 || m5.size() != 0) && guard < 10) begin
      step(1'b0, 1'b1, 8'h00);
      guard++;
    end
    total++;
    if ({e4, e5} !== 2'b11) begin
      bad++; $display("FAIL collide_drain got=%b exp=11", {e4, e5});
    end
    step(1'b1, 1'b1, 8'hA5);
    total++;
    if ({l4, l5, rd4, rd5} !== {3'd1, 4'd1, 8'hA5, 8'hA5}) begin
      bad++; $display("FAIL collide_empty got=%h exp=%h", {l4, l5, rd4, rd5}, {3'd1, 4'd1, 8'hA5, 8'hA5});
    end
    step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_errors();
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    total++;
    if ({l4, e4, f4, af4, ae4, ov4, un4, rd4} !== exp4()) begin
      bad++; $display("FAIL underflow_state4 got=%h exp=%h", {l4, e4, f4, af4, ae4, ov4, un4, rd4}, exp4());
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'(8'h80 + i));
      total++;
      if ({l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5} !== {exp4(), exp5()}) begin
        bad++; $display("FAIL overflow_state i=%0d got=%h exp=%h", i,
                        {l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5}, {exp4(), exp5()});
      end
    end
    step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 8'hC3);
    @(negedge clock);
    write_enable = 1'b0; read_enable = 1'b0;
    resetn = 1'b0;
    #1;
    clear_model();
    total++;
    if ({l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5, p1re4, p1re5} !==
        {exp4(), exp5(), 2'b00}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h",
                      {l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5, p1re4, p1re5},
                      {exp4(), exp5(), 2'b00});
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic we, re;
    logic [7:0] wd;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        we = $urandom_range(0, 99) < 70; re = $urandom_range(0, 99) < 40;
      end else begin
        we = $urandom_range(0, 99) < 35; re = $urandom_range(0, 99) < 70;
      end
      wd = 8'($urandom);
      write_enable = we; read_enable = re; write_data = wd;
      #1;
      total++;
      if ({p0we4, p1re4, p0we5, p1re5} !==
          {we && m4.size() < 4, m4.size() != 0, we && m5.size() < 5, m5.size() != 0}) begin
        bad++; $display("FAIL rand_ram_ctrl i=%0d got=%b exp=%b", i, {p0we4, p1re4, p0we5, p1re5},
                        {we && m4.size() < 4, m4.size() != 0, we && m5.size() < 5, m5.size() != 0});
      end
      step(we, re, wd);
      total++;
      if ({l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5} !== {exp4(), exp5()}) begin
        bad++; $display("FAIL rand_state i=%0d got=%h exp=%h", i,
                        {l4, e4, f4, af4, ae4, ov4, un4, rd4, l5, e5, f5, af5, ae5, ov5, un5, rd5}, {exp4(), exp5()});
      end
      total++;
      if ({p0a4, p1a4, p0a5, p1a5} !== {2'(wp4 % 4), 2'(rp4 % 4), 3'(wp5 % 5), 3'(rp5 % 5)}) begin
        bad++; $display("FAIL rand_pointers i=%0d got=%h exp=%h", i, {p0a4, p1a4, p0a5, p1a5},
                        {2'(wp4 % 4), 2'(rp4 % 4), 3'(wp5 % 5), 3'(rp5 % 5)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_collision();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
